decode_mc: RTL and testbench

//  Next-generation control decoder for the multi-cycle core. It combines the main control FSM,
//  the ALU/FPU decoder, PC logic and the instruction decoder in one block.
//  It adds a start/done handshake so multiply and FPU operations can take a variable number of

---
 rtl/decode_mc.sv | 221 ++++++++++++++++++++++
 tb/tb_decode_mc.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_mc.sv
// Multi-cycle core control decoder: main FSM, ALU/FPU decode, PC logic and a
// start/done handshake with watchdog for variable-latency multiply/FPU units.
module decode_mc #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 5,
  parameter bit          MUL_MC   = 1'b1,
  parameter bit          FPU_MC   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] MulOp,
  input  logic       ExDone,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       AdrSrc,
  output logic       PCS,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] FPUControl,
  output logic       ResSrc,
  output logic [1:0] FlagW,
  output logic [1:0] FPUFlagW,
  output logic       MulWrite,
  output logic       ExStart,
  output logic       ExSel,
  output logic       Fault
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] EXR     = 4'd6;
  localparam logic [3:0] EXI     = 4'd7;
  localparam logic [3:0] EXSTART = 4'd8;
  localparam logic [3:0] EXWAIT  = 4'd9;
  localparam logic [3:0] ALUWB   = 4'd10;
  localparam logic [3:0] BRANCH  = 4'd11;
  localparam logic [3:0] HALT    = 4'd12;

  logic [3:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             fault_q, fault_nx;
  logic             is_mul, long_op, wd_hit;
  logic             alu_op, branch, flag_en;
  logic [2:0]       alu_dec;

  assign is_mul  = (Op == 2'b00) && (MulOp == 4'b1001);
  assign long_op = ((Op == 2'b11) && FPU_MC) || (is_mul && MUL_MC);
  assign wd_hit  = (cnt == CNT_W'(MAX_WAIT - 1));
  assign Fault   = fault_q;

  // State, watchdog counter and sticky fault
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      cnt     <= '0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      fault_q <= fault_nx;
    end
  end

  // ALU operation decode; multiply family and unknown commands handled here
  always_comb begin
    alu_dec = 3'b000;
    if (is_mul) begin
      case (Funct[4:1])
        4'b0000: alu_dec = 3'b100;
        4'b0100: alu_dec = 3'b101;
        4'b0110: alu_dec = 3'b110;
        default: alu_dec = 3'b000;
      endcase
    end else if (Op == 2'b00) begin
      case (Funct[4:1])
        4'b0100: alu_dec = 3'b000;
        4'b0010: alu_dec = 3'b001;
        4'b0000: alu_dec = 3'b010;
        4'b1100: alu_dec = 3'b011;
        default: alu_dec = 3'b000;
      endcase
    end
  end

  // Next state and outputs; everything is forced low while reset is held
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    fault_nx   = fault_q;
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    AdrSrc     = 1'b0;
    PCS        = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    ALUControl = 3'b000;
    FPUControl = 2'b00;
    ResSrc     = 1'b0;
    FlagW      = 2'b00;
    FPUFlagW   = 2'b00;
    MulWrite   = 1'b0;
    ExStart    = 1'b0;
    ExSel      = 1'b0;
    alu_op     = 1'b0;
    branch     = 1'b0;
    flag_en    = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          IRWrite   = 1'b1;
          NextPC    = 1'b1;
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          state_nx  = DECODE;
        end
        DECODE: begin
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          if (Op == 2'b01)      state_nx = MEMADR;
          else if (Op == 2'b10) state_nx = BRANCH;
          else if (long_op)     state_nx = EXSTART;
          else if (Funct[5])    state_nx = EXI;
          else                  state_nx = EXR;
        end
        MEMADR: begin
          ALUSrcB  = 2'b01;
          state_nx = Funct[0] ? MEMRD : MEMWR;
        end
        MEMRD: begin
          AdrSrc   = 1'b1;
          state_nx = MEMWB;
        end
        MEMWB: begin
          RegW      = 1'b1;
          ResultSrc = 2'b01;
          state_nx  = FETCH;
        end
        MEMWR: begin
          AdrSrc   = 1'b1;
          MemW     = 1'b1;
          state_nx = FETCH;
        end
        EXR: begin
          alu_op   = 1'b1;
          flag_en  = 1'b1;
          state_nx = ALUWB;
        end
        EXI: begin
          ALUSrcB  = 2'b01;
          alu_op   = 1'b1;
          flag_en  = 1'b1;
          state_nx = ALUWB;
        end
        EXSTART: begin
          ExStart  = 1'b1;
          ExSel    = Op[1];
          cnt_nx   = '0;
          state_nx = EXWAIT;
        end
        EXWAIT: begin
          ExSel  = Op[1];
          alu_op = 1'b1;
          cnt_nx = cnt + CNT_W'(1);
          // A done on the last allowed cycle still completes normally
          if (ExDone) begin
            flag_en  = 1'b1;
            state_nx = ALUWB;
          end else if (wd_hit) begin
            fault_nx = 1'b1;
            state_nx = HALT;
          end
        end
        ALUWB: begin
          RegW     = 1'b1;
          MulWrite = is_mul && ((Funct[3:1] == 3'b100) || (Funct[3:1] == 3'b110));
          state_nx = FETCH;
        end
        BRANCH: begin
          ALUSrcA   = 2'b10;
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
          branch    = 1'b1;
          state_nx  = FETCH;
        end
        HALT:    state_nx = HALT;
        default: state_nx = FETCH;
      endcase
      if (alu_op) ALUControl = alu_dec;
      if (flag_en && (Op == 2'b00))
        FlagW = {Funct[0], Funct[0] & ((alu_dec == 3'b000) || (alu_dec == 3'b001))};
      if (flag_en && (Op == 2'b11))
        FPUFlagW = {Funct[0], 1'b0};
      ImmSrc     = Op;
      RegSrc     = {Op == 2'b01, Op == 2'b10};
      FPUControl = (Op == 2'b11) ? Funct[2:1] : 2'b00;
      ResSrc     = (Op == 2'b11);
      PCS        = ((Rd == 4'd15) & RegW) | branch;
    end
  end

endmodule

// File: tb/tb_decode_mc.sv
// Scoreboard bench for decode_mc: per-cycle expected control words are queued by
// the stimulus and compared by a negedge monitor; two configurations are exercised.
module tb_decode_mc;

  typedef struct packed {
    logic       irwrite, nextpc, regw, memw, adrsrc, pcs;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc, regsrc;
    logic [2:0] alucontrol;
    logic [1:0] fpucontrol;
    logic       ressrc;
    logic [1:0] flagw, fpuflagw;
    logic       mulwrite, exstart, exsel, fault;
  } outs_t;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                 S_MEMWR = 5, S_EXR = 6, S_EXI = 7, S_EXSTART = 8, S_EXWAIT = 9,
                 S_ALUWB = 10, S_BRANCH = 11, S_HALT = 12, S_RST = 13, S_RSTH = 14;
  localparam outs_t NONE = '0;

  logic clk;
  logic reset1, reset0, exdone1, exdone0;
  logic [1:0] op1, op0;
  logic [5:0] funct1, funct0;
  logic [3:0] rd1, rd0, mulop1, mulop0;

  logic irw1, npc1, regw1, memw1, adr1, pcs1, rsrc1, mulw1, exs1, exsel1, flt1;
  logic [1:0] rs1, sa1, sb1, imm1, rgs1, fpc1, fw1, ffw1;
  logic [2:0] ac1;
  logic irw0, npc0, regw0, memw0, adr0, pcs0, rsrc0, mulw0, exs0, exsel0, flt0;
  logic [1:0] rs0, sa0, sb0, imm0, rgs0, fpc0, fw0, ffw0;
  logic [2:0] ac0;

  outs_t act1, act0;
  assign act1 = {irw1, npc1, regw1, memw1, adr1, pcs1, rs1, sa1, sb1, imm1, rgs1, ac1, fpc1,
                 rsrc1, fw1, ffw1, mulw1, exs1, exsel1, flt1};
  assign act0 = {irw0, npc0, regw0, memw0, adr0, pcs0, rs0, sa0, sb0, imm0, rgs0, ac0, fpc0,
                 rsrc0, fw0, ffw0, mulw0, exs0, exsel0, flt0};

  decode_mc #(.MAX_WAIT(16), .CNT_W(5), .MUL_MC(1'b1), .FPU_MC(1'b1)) u_mc (
    .clk(clk), .reset(reset1), .Op(op1), .Funct(funct1), .Rd(rd1), .MulOp(mulop1),
    .ExDone(exdone1), .IRWrite(irw1), .NextPC(npc1), .RegW(regw1), .MemW(memw1),
    .AdrSrc(adr1), .PCS(pcs1), .ResultSrc(rs1), .ALUSrcA(sa1), .ALUSrcB(sb1),
    .ImmSrc(imm1), .RegSrc(rgs1), .ALUControl(ac1), .FPUControl(fpc1), .ResSrc(rsrc1),
    .FlagW(fw1), .FPUFlagW(ffw1), .MulWrite(mulw1), .ExStart(exs1), .ExSel(exsel1),
    .Fault(flt1));

  decode_mc #(.MAX_WAIT(16), .CNT_W(5), .MUL_MC(1'b0), .FPU_MC(1'b0)) u_sc (
    .clk(clk), .reset(reset0), .Op(op0), .Funct(funct0), .Rd(rd0), .MulOp(mulop0),
    .ExDone(exdone0), .IRWrite(irw0), .NextPC(npc0), .RegW(regw0), .MemW(memw0),
    .AdrSrc(adr0), .PCS(pcs0), .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0),
    .ImmSrc(imm0), .RegSrc(rgs0), .ALUControl(ac0), .FPUControl(fpc0), .ResSrc(rsrc0),
    .FlagW(fw0), .FPUFlagW(ffw0), .MulWrite(mulw0), .ExStart(exs0), .ExSel(exsel0),
    .Fault(flt0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  outs_t qv1[$], qm1[$], qv0[$], qm0[$];
  string qn1[$], qn0[$];

  // Hand-written per-state expectations taken from the control table
  function automatic outs_t tpl(input int st, input logic [1:0] op, input logic [5:0] fn);
    outs_t r = '0;
    if (st == S_RST || st == S_RSTH) return r;
    r.immsrc     = op;
    r.regsrc     = {op == 2'b01, op == 2'b10};
    r.fpucontrol = (op == 2'b11) ? fn[2:1] : 2'b00;
    r.ressrc     = (op == 2'b11);
    case (st)
      S_FETCH:   begin r.irwrite = 1'b1; r.nextpc = 1'b1; r.alusrca = 2'b01;
                       r.alusrcb = 2'b10; r.resultsrc = 2'b10; end
      S_DECODE:  begin r.alusrca = 2'b01; r.alusrcb = 2'b10; r.resultsrc = 2'b10; end
      S_BRANCH:  begin r.alusrca = 2'b10; r.alusrcb = 2'b01; r.resultsrc = 2'b10;
                       r.pcs = 1'b1; end
      S_MEMWB:   begin r.regw = 1'b1; r.resultsrc = 2'b01; end
      S_MEMWR:   r.memw = 1'b1;
      S_ALUWB:   r.regw = 1'b1;
      S_EXSTART: begin r.exstart = 1'b1; r.exsel = op[1]; end
      S_EXWAIT:  r.exsel = op[1];
      S_HALT:    r.fault = 1'b1;
      default:   ;
    endcase
    return r;
  endfunction

  function automatic outs_t tmask(input int st);
    outs_t m = '1;
    if (st == S_RST) return m;
    if (st == S_RSTH) begin m.fault = 1'b0; return m; end
    m.adrsrc = 1'b0;
    m.alucontrol = 3'b000;
    if (st == S_HALT) begin
      m.resultsrc = 2'b00; m.alusrca = 2'b00; m.alusrcb = 2'b00; m.immsrc = 2'b00;
      m.regsrc = 2'b00; m.fpucontrol = 2'b00; m.ressrc = 1'b0; m.exsel = 1'b0;
    end else if (st != S_FETCH && st != S_DECODE && st != S_BRANCH) begin
      m.alusrca = 2'b00; m.alusrcb = 2'b00;
      if (st != S_MEMWB && st != S_ALUWB) m.resultsrc = 2'b00;
    end
    return m;
  endfunction

  function automatic outs_t xa(input logic [2:0] ac, input logic [1:0] fw, input logic [1:0] ffw);
    outs_t r = '0;
    r.alucontrol = ac; r.flagw = fw; r.fpuflagw = ffw;
    return r;
  endfunction

  function automatic outs_t xw(input logic mw, input logic pc);
    outs_t r = '0;
    r.mulwrite = mw; r.pcs = pc;
    return r;
  endfunction

  // Queue the expected word for the current cycle, then advance one cycle
  task automatic cyc(input int id, input string nm, input int st, input outs_t x, input bit ac);
    outs_t e, m;
    e = (id == 1) ? tpl(st, op1, funct1) : tpl(st, op0, funct0);
    e = e | x;
    m = tmask(st);
    if (ac) m.alucontrol = 3'b111;
    if (id == 1) begin qv1.push_back(e); qm1.push_back(m); qn1.push_back(nm); end
    else begin qv0.push_back(e); qm0.push_back(m); qn0.push_back(nm); end
    @(posedge clk); #1;
  endtask

  task automatic set1(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                      input logic [3:0] mop);
    op1 = op; funct1 = fn; rd1 = rd; mulop1 = mop;
  endtask

  task automatic set0(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                      input logic [3:0] mop);
    op0 = op; funct0 = fn; rd0 = rd; mulop0 = mop;
  endtask

  task automatic chk(input string nm, input outs_t a, input outs_t e, input outs_t m);
    n_chk++;
    if (((a ^ e) & m) !== '0) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (mask %h)", nm, a, e, m);
    end
  endtask

  // Monitor: every queued cycle is compared mid-cycle
  always @(negedge clk) begin
    if (qv1.size() != 0) chk(qn1.pop_front(), act1, qv1.pop_front(), qm1.pop_front());
    if (qv0.size() != 0) chk(qn0.pop_front(), act0, qv0.pop_front(), qm0.pop_front());
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want end of stimulus");
    $fatal(1);
  end

  initial begin
    reset1 = 1'b1; reset0 = 1'b1; exdone1 = 1'b0; exdone0 = 1'b0;
    set1(2'b00, 6'b000000, 4'd0, 4'd0);
    set0(2'b00, 6'b000000, 4'd0, 4'd0);
    @(posedge clk); #1;
    cyc(1, "reset_mc", S_RST, NONE, 1'b1);
    cyc(0, "reset_sc", S_RST, NONE, 1'b1);

    // ADD: 4 cycles, no flags
    set1(2'b00, 6'b001000, 4'd1, 4'd0);
    reset1 = 1'b0;
    cyc(1, "add_fetch", S_FETCH, NONE, 1'b0);
    cyc(1, "add_decode", S_DECODE, NONE, 1'b0);
    cyc(1, "add_exr", S_EXR, xa(3'b000, 2'b00, 2'b00), 1'b1);
    cyc(1, "add_wb", S_ALUWB, NONE, 1'b0);
    // SUBS: both flag enables
    set1(2'b00, 6'b000101, 4'd2, 4'd0);
    cyc(1, "subs_fetch", S_FETCH, NONE, 1'b0);
    cyc(1, "subs_decode", S_DECODE, NONE, 1'b0);
    cyc(1, "subs_exr", S_EXR, xa(3'b001, 2'b11, 2'b00), 1'b1);
    cyc(1, "subs_wb", S_ALUWB, NONE, 1'b0);
    // ORRS immediate: EXI path, only upper flag enable
    set1(2'b00, 6'b111001, 4'd4, 4'd0);
    cyc(1, "orrs_fetch", S_FETCH, NONE, 1'b0);
    cyc(1, "orrs_decode", S_DECODE, NONE, 1'b0);
    cyc(1, "orrs_exi", S_EXI, xa(3'b011, 2'b10, 2'b00), 1'b1);
    cyc(1, "orrs_wb", S_ALUWB, NONE, 1'b0);
    // Undefined cmd writing R15: ADD control, PCS from RegW
    set1(2'b00, 6'b011110, 4'd15, 4'd0);
    cyc(1, "undef_fetch", S_FETCH, NONE, 1'b0);
    cyc(1, "undef_decode", S_DECODE, NONE, 1'b0);
    cyc(1, "undef_exr", S_EXR, xa(3'b000, 2'b00, 2'b00), 1'b1);
    cyc(1, "undef_wb", S_ALUWB, xw(1'b0, 1'b1), 1'b0);
    // UMULL via handshake; done during EXSTART is ignored, done on wait cycle 3
    set1(2'b00, 6'b001001, 4'd5, 4'b1001);
    cyc(1, "umull_fetch", S_FETCH, NONE, 1'b0);
    cyc(1, "umull_decode", S_DECODE, NONE, 1'b0);
    exdone1 = 1'b1;
    cyc(1, "umull_start", S_EXSTART, NONE, 1'b0);
    exdone1 = 1'b0;
    cyc(1, "umull_wait1", S_EXWAIT, NONE, 1'b0);
    cyc(1, "umull_wait2", S_EXWAIT, NONE, 1'b0);
    exdone1 = 1'b1;
    cyc(1, "umull_done", S_EXWAIT, xa(3'b101, 2'b10, 2'b00), 1'b1);
    exdone1 = 1'b0;
    cyc(1, "umull_wb", S_ALUWB, xw(1'b1, 1'b0), 1'b0);
    // LDR to PC, STR, B
    set1(2'b01, 6'b011001, 4'd15, 4'd0);
    cyc(1, "ldr_fetch", S_FETCH, NONE, 1'b0);
    cyc(1, "ldr_decode", S_DECODE, NONE, 1'b0);
    cyc(1, "ldr_adr", S_MEMADR, NONE, 1'b0);
    cyc(1, "ldr_rd", S_MEMRD, NONE, 1'b0);
    cyc(1, "ldr_wb", S_MEMWB, xw(1'b0, 1'b1), 1'b0);
    set1(2'b01, 6'b011000, 4'd3, 4'd0);
    cyc(1, "str_fetch", S_FETCH, NONE, 1'b0);
    cyc(1, "str_decode", S_DECODE, NONE, 1'b0);
    cyc(1, "str_adr", S_MEMADR, NONE, 1'b0);
    cyc(1, "str_wr", S_MEMWR, NONE, 1'b0);
    set1(2'b10, 6'b100000, 4'd0, 4'd0);
    cyc(1, "b_fetch", S_FETCH, NONE, 1'b0);
    cyc(1, "b_decode", S_DECODE, NONE, 1'b0);
    cyc(1, "b_branch", S_BRANCH, NONE, 1'b0);
    // FPU op never completes: 16 wait cycles then sticky HALT
    set1(2'b11, 6'b000111, 4'd6, 4'd0);
    cyc(1, "fpu_fetch", S_FETCH, NONE, 1'b0);
    cyc(1, "fpu_decode", S_DECODE, NONE, 1'b0);
    cyc(1, "fpu_start", S_EXSTART, NONE, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1, "fpu_wait", S_EXWAIT, NONE, 1'b0);
    cyc(1, "fpu_halt1", S_HALT, NONE, 1'b0);
    exdone1 = 1'b1;
    cyc(1, "fpu_halt2", S_HALT, NONE, 1'b0);
    exdone1 = 1'b0;
    cyc(1, "fpu_halt3", S_HALT, NONE, 1'b0);
    reset1 = 1'b1;
    cyc(1, "halt_reset", S_RSTH, NONE, 1'b1);
    reset1 = 1'b0;
    // Reset during EXWAIT, late done ignored, then done on the last allowed cycle
    cyc(1, "fpu2_fetch", S_FETCH, NONE, 1'b0);
    cyc(1, "fpu2_decode", S_DECODE, NONE, 1'b0);
    cyc(1, "fpu2_start", S_EXSTART, NONE, 1'b0);
    cyc(1, "fpu2_wait1", S_EXWAIT, NONE, 1'b0);
    cyc(1, "fpu2_wait2", S_EXWAIT, NONE, 1'b0);
    reset1 = 1'b1;
    cyc(1, "wait_reset", S_RST, NONE, 1'b1);
    reset1 = 1'b0;
    exdone1 = 1'b1;
    cyc(1, "fpu3_fetch", S_FETCH, NONE, 1'b0);
    exdone1 = 1'b0;
    cyc(1, "fpu3_decode", S_DECODE, NONE, 1'b0);
    cyc(1, "fpu3_start", S_EXSTART, NONE, 1'b0);
    for (int i = 0; i < 15; i++) cyc(1, "fpu3_wait", S_EXWAIT, NONE, 1'b0);
    exdone1 = 1'b1;
    cyc(1, "fpu3_done_last", S_EXWAIT, xa(3'b000, 2'b00, 2'b10), 1'b1);
    exdone1 = 1'b0;
    cyc(1, "fpu3_wb", S_ALUWB, NONE, 1'b0);
    cyc(1, "fpu3_next", S_FETCH, NONE, 1'b0);

    // Single-cycle configuration: UMULL, MUL and FPU take the EXR path
    set0(2'b00, 6'b001001, 4'd5, 4'b1001);
    reset0 = 1'b0;
    cyc(0, "sc_umull_fetch", S_FETCH, NONE, 1'b0);
    cyc(0, "sc_umull_decode", S_DECODE, NONE, 1'b0);
    cyc(0, "sc_umull_exr", S_EXR, xa(3'b101, 2'b10, 2'b00), 1'b1);
    cyc(0, "sc_umull_wb", S_ALUWB, xw(1'b1, 1'b0), 1'b0);
    set0(2'b00, 6'b000001, 4'd7, 4'b1001);
    cyc(0, "sc_mul_fetch", S_FETCH, NONE, 1'b0);
    cyc(0, "sc_mul_decode", S_DECODE, NONE, 1'b0);
    cyc(0, "sc_mul_exr", S_EXR, xa(3'b100, 2'b10, 2'b00), 1'b1);
    cyc(0, "sc_mul_wb", S_ALUWB, NONE, 1'b0);
    set0(2'b11, 6'b000111, 4'd6, 4'd0);
    cyc(0, "sc_fpu_fetch", S_FETCH, NONE, 1'b0);
    cyc(0, "sc_fpu_decode", S_DECODE, NONE, 1'b0);
    cyc(0, "sc_fpu_exr", S_EXR, xa(3'b000, 2'b00, 2'b10), 1'b1);
    cyc(0, "sc_fpu_wb", S_ALUWB, NONE, 1'b0);
    cyc(0, "sc_fpu_next", S_FETCH, NONE, 1'b0);

    repeat (2) @(posedge clk);
    n_chk++;
    if (qv1.size() != 0 || qv0.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", qv1.size(), qv0.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
